// File: rtl/apb_master_bridge.sv
// APB3 initiator: runs one memory-stage load/store as an APB transfer and reports completion.
// Optional PREADY timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_BITS       = 2,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    trans_en,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    trans_done,
   output logic                    store_done,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    err,
   output logic                    busy,
   output logic [2**SEL_BITS-1:0]  PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int NUM_SLAVES = 2**SEL_BITS;

   // Handshake: trans_en is a held request; fields stay stable until the single-cycle
   // trans_done pulse. The request is only sampled in IDLE, so the DONE cycle never retriggers.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [SEL_BITS-1:0] req_idx;
   logic [SEL_BITS-1:0] sel_idx;
   logic                decode_miss;
   logic                err_q;
   logic                timeout_hit;

   assign req_idx     = req_addr[SEL_LSB +: SEL_BITS];
   assign decode_miss = (int'(req_idx) >= NUM_SLAVES);

`ifdef APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;

   // Counts ACCESS cycles already spent; cleared in SETUP so every transfer starts fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == SETUP) begin
         to_cnt <= '0;
      end else if (state == ACCESS) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state == ACCESS) && !PREADY && (to_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      PSEL       = '0;
      PENABLE    = 1'b0;
      busy       = 1'b0;
      trans_done = 1'b0;
      store_done = 1'b0;
      err        = 1'b0;
      case (state)
         IDLE: begin
            if (trans_en) begin
               state_nxt = decode_miss ? DONE : SETUP;
            end
         end
         SETUP: begin
            PSEL[sel_idx] = 1'b1;
            busy          = 1'b1;
            state_nxt     = ACCESS;
         end
         ACCESS: begin
            PSEL[sel_idx] = 1'b1;
            PENABLE       = 1'b1;
            busy          = 1'b1;
            if (PREADY || timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            trans_done = 1'b1;
            store_done = PWRITE;
            err        = err_q;
            state_nxt  = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // APB address/data phase registers; they keep their last values while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         PADDR   <= '0;
         PWDATA  <= '0;
         PWRITE  <= 1'b0;
         sel_idx <= '0;
         err_q   <= 1'b0;
         rd_data <= '0;
      end else begin
         if ((state == IDLE) && trans_en) begin
            PADDR   <= req_addr;
            PWDATA  <= req_wdata;
            PWRITE  <= req_write;
            sel_idx <= req_idx;
            err_q   <= decode_miss;
         end
         if (state == ACCESS) begin
            if (PREADY) begin
               err_q <= PSLVERR;
               if (!PWRITE) begin
                  rd_data <= PRDATA;
               end
            end else if (timeout_hit) begin
               err_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed cases plus randomized transfers
// checked against a cycle-count/data reference model.
module tb_apb_master_bridge;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        trans_en;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        trans_done;
   logic        store_done;
   logic [31:0] rd_data;
   logic        err;
   logic        busy;
   logic [3:0]  PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_rd;

   apb_master_bridge dut (
      .clk        (clk),
      .rst        (rst),
      .trans_en   (trans_en),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .trans_done (trans_done),
      .store_done (store_done),
      .rd_data    (rd_data),
      .err        (err),
      .busy       (busy),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PWRITE     (PWRITE),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transfer from an IDLE-cycle negedge to the following IDLE-cycle negedge.
   // Model: DONE comes 2 + (ACCESS cycles) after acceptance; ACCESS lasts waits+1
   // cycles, or TO cycles if the optional timeout fires first.
   task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdat, input bit slverr,
                           input bit flush);
      int          access_n;
      bit          timed_out;
      bit          ready;
      logic [3:0]  exp_sel;
      logic [31:0] exp_data;
      logic [1:0]  idx;
      idx       = addr[13:12];
      exp_sel   = 4'b0001 << idx;
      timed_out = 1'b0;
      access_n  = waits + 1;
`ifdef APB_TIMEOUT_EN
      if (waits >= TO) begin
         timed_out = 1'b1;
         access_n  = TO;
      end
`endif
      exp_q.push_back((!wr && !timed_out) ? rdat : exp_rd);

      check("idle_busy", busy, 0);
      check("idle_psel", PSEL, 0);
      trans_en  = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wdata;
      PREADY    = 1'b0;
      step();

      check("setup_psel", PSEL, exp_sel);
      check("setup_penable", PENABLE, 0);
      check("setup_busy", busy, 1);
      check("setup_paddr", PADDR, addr);
      check("setup_pwrite", PWRITE, wr);
      check("setup_pwdata", PWDATA, wdata);
      check("setup_done", trans_done, 0);
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
      if (flush) trans_en = 1'b0;
      step();

      for (int k = 0; k < access_n; k++) begin
         check("access_psel", PSEL, exp_sel);
         check("access_penable", PENABLE, 1);
         check("access_paddr", PADDR, addr);
         check("access_pwrite", PWRITE, wr);
         check("access_pwdata", PWDATA, wdata);
         check("access_done", trans_done, 0);
         ready   = !timed_out && (k == access_n - 1);
         PREADY  = ready;
         PRDATA  = ready ? rdat : $urandom;
         PSLVERR = ready ? slverr : 1'($urandom_range(0, 1));
         step();
      end

      PREADY   = 1'b0;
      exp_data = exp_q.pop_front();
      exp_rd   = exp_data;
      check("done_pulse", trans_done, 1);
      check("done_store", store_done, wr);
      check("done_err", err, timed_out ? 1'b1 : slverr);
      check("done_rd_data", rd_data, exp_data);
      check("done_psel", PSEL, 0);
      check("done_penable", PENABLE, 0);
      check("done_busy", busy, 0);
      step();
      check("post_done", trans_done, 0);
   endtask

   task automatic idle_gap(input int n);
      trans_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         check("gap_done", trans_done, 0);
         check("gap_busy", busy, 0);
         check("gap_rd_data", rd_data, exp_rd);
      end
   endtask

   initial begin
      rst       = 1'b1;
      trans_en  = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      PRDATA    = '0;
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      exp_rd    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_done", trans_done, 0);
      check("rst_store", store_done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      step();

      // Zero-wait read, 3-wait write, erroring read.
      run_xfer(1'b0, 32'h0000_1004, 32'h0, 0, 32'hA5A5_0001, 1'b0, 1'b0);
      idle_gap(1);
      run_xfer(1'b1, 32'h0000_2000, 32'h55, 3, 32'h0, 1'b0, 1'b0);
      idle_gap(2);
      run_xfer(1'b0, 32'h0000_0010, 32'h0, 1, 32'h0000_DEAD, 1'b1, 1'b0);
      idle_gap(1);

      // Back-to-back reads with trans_en held across both.
      run_xfer(1'b0, 32'h0000_3000, 32'h0, 0, 32'h1111_2222, 1'b0, 1'b0);
      run_xfer(1'b0, 32'h0000_1ffc, 32'h0, 0, 32'h3333_4444, 1'b0, 1'b0);
      idle_gap(1);

      // Flushed request still completes.
      run_xfer(1'b1, 32'h0000_2040, 32'hCAFE_F00D, 2, 32'h0, 1'b0, 1'b1);
      idle_gap(1);

      // Boundary waits: completes on the last allowed ACCESS cycle, then a stuck slave.
      run_xfer(1'b0, 32'h0000_1008, 32'h0, TO - 1, 32'h0BAD_BEEF, 1'b0, 1'b0);
      idle_gap(1);
      run_xfer(1'b0, 32'h0000_300c, 32'h0, TO + 4, 32'h7777_8888, 1'b0, 1'b0);
      idle_gap(1);

      // Reset in ACCESS with PREADY low.
      trans_en  = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_3010;
      PREADY    = 1'b0;
      step();
      check("abort_setup_busy", busy, 1);
      step();
      check("abort_access_penable", PENABLE, 1);
      rst = 1'b1;
      step();
      check("abort_psel", PSEL, 0);
      check("abort_penable", PENABLE, 0);
      check("abort_busy", busy, 0);
      check("abort_done", trans_done, 0);
      rst    = 1'b0;
      exp_rd = '0;
      idle_gap(3);

      // Randomized transfers.
      for (int n = 0; n < 24; n++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_CFFC) | (32'($urandom_range(0, 3)) << 12);
         run_xfer(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 4), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 2));
      end
      idle_gap(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
